vram_wr_arb: RTL and testbench
==============================

VRAM_WR_ARB -- requirements
Module: vram_wr_arb

Interface
REQ-001 Parameter COLS, 25, grid columns.
REQ-002 Parameter ROWS, 15, grid rows; COLS*ROWS = 375 cells, which equals the vram depth.
REQ-003 clk  in  1  single clock; drives all state; the vram clka port is tied to the same net.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 clr_start  in  1  single-cycle request to fill the whole screen with clr_color.
REQ-006 clr_color  in  4  fill colour; latched when clr_start is accepted.
REQ-007 clr_busy  out  1  high while the fill sweep runs.
REQ-008 clr_done  out  1  one-cycle pulse when the sweep completes.
REQ-009 req  in  3  write requests; bit 0 tail-erase, bit 1 head-draw, bit 2 food-draw.
REQ-010 req_x  in  15  column per port, 5 bits each; port i occupies bits [5i+4:5i].
REQ-011 req_y  in  12  row per port, 4 bits each.
REQ-012 req_color  in  12  colour per port, 4 bits each.
REQ-013 ack  out  3  one-cycle grant pulse per port.
REQ-014 err  out  3  one-cycle pulse per port; asserted together with ack when the coordinate is out of range.
REQ-015 vram_addr  out  9  connects to vram addra.
REQ-016 vram_din  out  4  connects to vram dia.

Function
REQ-017 The vram write port writes on every clk edge. The block SHALL hold the last vram_addr and vram_din when idle, so that an idle cycle rewrites the same cell with the same value.
REQ-018 FSM states: IDLE and CLEAR.
- IDLE -> CLEAR when clr_start = 1.
- CLEAR -> IDLE after the cell at address COLS*ROWS-1 has been presented.
REQ-019 IDLE, clr_start sampled at edge N: vram_addr = 0 and vram_din = clr_color after edge N; clr_busy = 1.
REQ-020 CLEAR: vram_addr increments by 1 per cycle with vram_din constant; address 374 is presented after edge N+374.
REQ-021 Edge N+375: state returns to IDLE, clr_busy = 0, and clr_done pulses for one cycle; total busy time is 375 cycles.
REQ-022 clr_start during CLEAR SHALL be ignored, with no restart.
REQ-023 In CLEAR no ack SHALL be issued; requests stay pending.
REQ-024 clr_start and any req at the same edge: the clear wins and no ack is issued that cycle.
REQ-025 Arbitration in IDLE is fixed priority: tail-erase (0) > head-draw (1) > food-draw (2). At most one grant per cycle.
REQ-026 A port granted at edge N is ineligible at edge N+1; this absorbs a requester's one-cycle req-drop delay and prevents a double write.
REQ-027 Grant at edge N, in-range coordinate:
- vram_addr = y*COLS + x after edge N;
- vram_din = that port's colour;
- ack[i] high for the following cycle;
- the RAM writes at edge N+1.
REQ-028 Address arithmetic is 9-bit unsigned, y*25 = (y<<4)+(y<<3)+y; the maximum legal address is 374.
REQ-029 x >= COLS or y >= ROWS: ack[i] and err[i] pulse together; vram_addr and vram_din are unchanged and no new write occurs.
REQ-030 Requesters SHALL hold req and payload stable until ack; payload changes before ack are undefined.
REQ-031 Leaving CLEAR: pending requests are arbitrated from the first IDLE edge, i.e. the cycle clr_done is high.

Reset
REQ-032 rst = 1 at an edge:
- state = IDLE;
- vram_addr = 0, vram_din = 0;
- clr_busy, clr_done, ack and err = 0;
- the grant mask is cleared.
REQ-033 While rst is held, cell 0 is rewritten with 0; this is accepted behaviour.
REQ-034 rst during CLEAR aborts the sweep with no clr_done; the remaining cells keep their old contents.

Structure
REQ-035 The shared package snake_vram_pkg SHALL hold COLS, ROWS, ADDR_W = 9, COLOR_W = 4 and the port index constants PORT_TAIL, PORT_HEAD and PORT_FOOD.
REQ-036 One combinational sub-module, vram_xy2addr, SHALL perform the (x, y) -> address conversion and the range check, with outputs addr and oob.
REQ-037 The arbiter, mask and FSM SHALL be in vram_wr_arb; the vram instance sits outside, in the top level.

Verification
REQ-038 Reset then idle for 10 cycles: vram_addr = 0, vram_din = 0, all acks 0, clr_busy 0.
REQ-039 req[1] with x = 3, y = 2, colour 5: after 1 cycle vram_addr = 53 and vram_din = 5; ack[1] lasts one cycle; a read via port B of 53 returns 5.
REQ-040 req = 3'b111 all held, with port payloads (1,0,c0) / (2,0,c1) / (3,0,c2) on ports 0/1/2 and each port dropping req after its ack:
- acks arrive in order port 0, port 1, port 2, one per cycle;
- addresses 1, 2, 3;
- no duplicate ack.
REQ-041 clr_start with clr_color = 7 while req[2] is pending:
- clr_busy stays high for exactly 375 cycles;
- a port B readback shows 7 in all cells 0..374;
- clr_done pulses;
- ack[2] follows on the clr_done cycle.
REQ-042 req[0] with x = 25, y = 0, or with x = 0, y = 15: ack[0] and err[0] pulse; vram_addr and vram_din are unchanged.
REQ-043 rst asserted 100 cycles into a sweep:
- outputs reset immediately;
- there is no clr_done;
- a new clr_start completes a full sweep normally.

Source files
------------

// File: rtl/snake_vram_pkg.sv
// Shared grid geometry, bus widths and requester port indices for the snake vram writers.
// Combinational constants only; no latency or flow control.
package snake_vram_pkg;

  localparam int COLS      = 25;
  localparam int ROWS      = 15;
  localparam int CELLS     = COLS * ROWS;
  localparam int ADDR_W    = 9;
  localparam int COLOR_W   = 4;
  localparam int X_W       = 5;
  localparam int Y_W       = 4;
  localparam int NPORT     = 3;

  localparam int PORT_TAIL = 0;
  localparam int PORT_HEAD = 1;
  localparam int PORT_FOOD = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vram_xy2addr.sv
// Grid (x, y) to linear vram address plus out-of-range flag; purely combinational, no backpressure.
module vram_xy2addr
  import snake_vram_pkg::*;
#(
  parameter int COLS = snake_vram_pkg::COLS,
  parameter int ROWS = snake_vram_pkg::ROWS
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              oob
);

  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  // Constant multiply folds to shift-add; 15*25+31 still fits in 9 bits.
  always_comb begin
    addr = ADDR_W'(y) * COLS_A + ADDR_W'(x);
    oob  = (int'(x) >= COLS) || (int'(y) >= ROWS);
  end

endmodule

// File: rtl/vram_wr_arb.sv
// Single-writer arbiter for the vram port: full-screen clear sweep plus fixed-priority pixel writes.
// One-cycle grant latency; requesters hold req until ack, a clear in progress stalls all requests.
module vram_wr_arb
  import snake_vram_pkg::*;
#(
  parameter int COLS = snake_vram_pkg::COLS,
  parameter int ROWS = snake_vram_pkg::ROWS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_start,
  input  logic [COLOR_W-1:0]       clr_color,
  output logic                     clr_busy,
  output logic                     clr_done,
  input  logic [NPORT-1:0]         req,
  input  logic [NPORT*X_W-1:0]     req_x,
  input  logic [NPORT*Y_W-1:0]     req_y,
  input  logic [NPORT*COLOR_W-1:0] req_color,
  output logic [NPORT-1:0]         ack,
  output logic [NPORT-1:0]         err,
  output logic [ADDR_W-1:0]        vram_addr,
  output logic [COLOR_W-1:0]       vram_din
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  arb_state_t          state, state_nxt;
  logic [NPORT-1:0]    mask, mask_nxt;
  logic [NPORT-1:0]    eligible;
  logic                grant_vld;
  logic [1:0]          gsel;
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [COLOR_W-1:0]  sel_color;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_oob;

  logic [ADDR_W-1:0]   addr_nxt;
  logic [COLOR_W-1:0]  din_nxt;
  logic [NPORT-1:0]    ack_nxt, err_nxt;
  logic                busy_nxt, done_nxt;

  // The port granted last edge is masked so its late req-drop cannot win twice.
  always_comb begin
    eligible  = req & ~mask;
    grant_vld = 1'b0;
    gsel      = 2'd0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_vld = 1'b1;
        gsel      = 2'(i);
      end
    end
    sel_x     = req_x[int'(gsel)*X_W +: X_W];
    sel_y     = req_y[int'(gsel)*Y_W +: Y_W];
    sel_color = req_color[int'(gsel)*COLOR_W +: COLOR_W];
  end

  vram_xy2addr #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_xy2addr (
    .x    (sel_x),
    .y    (sel_y),
    .addr (sel_addr),
    .oob  (sel_oob)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = vram_addr;
    din_nxt   = vram_din;
    ack_nxt   = '0;
    err_nxt   = '0;
    busy_nxt  = clr_busy;
    done_nxt  = 1'b0;
    mask_nxt  = '0;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_nxt = ST_CLEAR;
          addr_nxt  = '0;
          din_nxt   = clr_color;
          busy_nxt  = 1'b1;
        end else if (grant_vld) begin
          ack_nxt[gsel]  = 1'b1;
          mask_nxt[gsel] = 1'b1;
          if (sel_oob) begin
            err_nxt[gsel] = 1'b1;
          end else begin
            addr_nxt = sel_addr;
            din_nxt  = sel_color;
          end
        end
      end
      ST_CLEAR: begin
        if (vram_addr == LAST_ADDR) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          addr_nxt = vram_addr + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mask      <= '0;
      vram_addr <= '0;
      vram_din  <= '0;
      ack       <= '0;
      err       <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mask      <= mask_nxt;
      vram_addr <= addr_nxt;
      vram_din  <= din_nxt;
      ack       <= ack_nxt;
      err       <= err_nxt;
      clr_busy  <= busy_nxt;
      clr_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_vram_wr_arb.sv
// Bench for vram_wr_arb: reference model plus vram array, per-cycle compare and directed checks.
module tb_vram_wr_arb;
  import snake_vram_pkg::*;

  logic                     clk;
  logic                     rst;
  logic                     clr_start;
  logic [COLOR_W-1:0]       clr_color;
  logic                     clr_busy;
  logic                     clr_done;
  logic [NPORT-1:0]         req;
  logic [NPORT*X_W-1:0]     req_x;
  logic [NPORT*Y_W-1:0]     req_y;
  logic [NPORT*COLOR_W-1:0] req_color;
  logic [NPORT-1:0]         ack;
  logic [NPORT-1:0]         err;
  logic [ADDR_W-1:0]        vram_addr;
  logic [COLOR_W-1:0]       vram_din;

  int errors = 0;
  int checks = 0;

  vram_wr_arb dut (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_color (req_color),
    .ack       (ack),
    .err       (err),
    .vram_addr (vram_addr),
    .vram_din  (vram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vram stand-in: writes every edge, read back directly as port B
  int mem [CELLS];
  always @(posedge clk) begin
    if (int'(vram_addr) < CELLS) mem[vram_addr] = int'(vram_din);
  end

  // reference model
  bit       m_on = 0;
  bit       m_clearing;
  int       m_pos, m_last, m_addr, m_din, m_busy, m_done;
  bit [2:0] m_ack, m_err;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1; m_clearing = 0; m_pos = 0; m_last = -1;
      m_addr = 0; m_din = 0; m_busy = 0; m_done = 0; m_ack = 0; m_err = 0;
    end else if (m_on) begin
      m_ack = 0; m_err = 0; m_done = 0;
      if (m_clearing) begin
        m_last = -1;
        if (m_pos == CELLS - 1) begin
          m_clearing = 0; m_busy = 0; m_done = 1;
        end else begin
          m_pos++; m_addr = m_pos;
        end
      end else if (clr_start) begin
        m_clearing = 1; m_pos = 0; m_addr = 0; m_din = int'(clr_color); m_busy = 1; m_last = -1;
      end else begin
        int g, x, y;
        g = -1;
        for (int i = 0; i < NPORT; i++)
          if (g < 0 && req[i] && i != m_last) g = i;
        m_last = g;
        if (g >= 0) begin
          x = int'(req_x[g*X_W +: X_W]);
          y = int'(req_y[g*Y_W +: Y_W]);
          m_ack[g] = 1'b1;
          if (x >= COLS || y >= ROWS) m_err[g] = 1'b1;
          else begin
            m_addr = y * COLS + x;
            m_din  = int'(req_color[g*COLOR_W +: COLOR_W]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      checks++;
      if (int'(vram_addr) != m_addr || int'(vram_din) != m_din || ack !== m_ack || err !== m_err ||
          int'(clr_busy) != m_busy || int'(clr_done) != m_done) begin
        errors++;
        $display("FAIL model_cmp t=%0t: dut addr=%0d din=%0d ack=%b err=%b busy=%b done=%b; model addr=%0d din=%0d ack=%b err=%b busy=%0d done=%0d",
                 $time, vram_addr, vram_din, ack, err, clr_busy, clr_done,
                 m_addr, m_din, m_ack, m_err, m_busy, m_done);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Issue clr_start, then count busy cycles until clr_done (bounded).
  task automatic run_sweep(input int col, input bit poke_mid, output int busy_cnt, output bit done_seen);
    int guard;
    clr_color = 4'(col);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    busy_cnt  = int'(clr_busy);
    done_seen = 1'b0;
    guard     = 0;
    while (!clr_done && guard < 600) begin
      clr_start = (poke_mid && guard == 50);
      tick();
      guard++;
      if (clr_busy) busy_cnt++;
    end
    clr_start = 1'b0;
    done_seen = clr_done;
  endtask

  function automatic int count_not(input int col);
    int n;
    n = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] != col) n++;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int       n, bc, k, dn;
    bit       ds;
    bit [2:0] prev;
    int       ord [3];
    int       adr [3];
    int       a, d;

    rst = 1'b1; clr_start = 1'b0; clr_color = '0;
    req = '0; req_x = '0; req_y = '0; req_color = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("idle_addr", int'(vram_addr), 0);
    check("idle_din", int'(vram_din), 0);
    check("idle_ack", int'(ack), 0);
    check("idle_busy", int'(clr_busy), 0);

    // head draw at (3,2), colour 5
    req_x[9:5] = 5'd3; req_y[7:4] = 4'd2; req_color[7:4] = 4'd5;
    req[PORT_HEAD] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ack[PORT_HEAD] && n < 20);
    check("head_latency", n, 1);
    check("head_ack", int'(ack), 2);
    check("head_addr", int'(vram_addr), 53);
    check("head_din", int'(vram_din), 5);
    req[PORT_HEAD] = 1'b0;
    tick();
    check("head_ack_pulse", int'(ack), 0);
    tick();
    check("head_mem53", mem[53], 5);

    // all three ports, each drops req one cycle after its ack
    req_x = {5'd3, 5'd2, 5'd1}; req_y = '0; req_color = {4'hC, 4'hB, 4'hA};
    req = 3'b111;
    prev = '0; k = 0;
    for (int i = 0; i < 3; i++) begin ord[i] = -1; adr[i] = -1; end
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < NPORT; i++) if (prev[i]) req[i] = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
        if (ack[i]) begin
          if (k < 3) begin ord[k] = i; adr[k] = int'(vram_addr); end
          k++;
        end
      end
      prev = ack;
    end
    check("multi_ack_count", k, 3);
    check("multi_ord0", ord[0], 0);
    check("multi_ord1", ord[1], 1);
    check("multi_ord2", ord[2], 2);
    check("multi_addr0", adr[0], 1);
    check("multi_addr1", adr[1], 2);
    check("multi_addr2", adr[2], 3);
    check("multi_mem3", mem[3], 12);

    // clear with food request pending at the same edge; a mid-sweep clr_start is ignored
    req = '0;
    req_x[14:10] = 5'd4; req_y[11:8] = 4'd1; req_color[11:8] = 4'd9;
    req[PORT_FOOD] = 1'b1;
    run_sweep(7, 1'b1, bc, ds);
    check("clr_busy_cycles", bc, CELLS);
    check("clr_done_seen", int'(ds), 1);
    check("clr_no_ack_on_done", int'(ack), 0);
    check("clr_cells_not7", count_not(7), 0);
    tick();
    check("food_ack_after_done", int'(ack), 4);
    check("food_addr", int'(vram_addr), 29);
    req[PORT_FOOD] = 1'b0;
    tick();
    check("clr_done_pulse", int'(clr_done), 0);

    // out-of-range tail erase: x=25,y=0 then x=0,y=15
    for (int t = 0; t < 2; t++) begin
      a = int'(vram_addr); d = int'(vram_din);
      req_x[4:0] = (t == 0) ? 5'd25 : 5'd0;
      req_y[3:0] = (t == 0) ? 4'd0 : 4'd15;
      req_color[3:0] = 4'd3;
      req[PORT_TAIL] = 1'b1;
      tick();
      check("oob_ack", int'(ack), 1);
      check("oob_err", int'(err), 1);
      check("oob_addr_hold", int'(vram_addr), a);
      check("oob_din_hold", int'(vram_din), d);
      req[PORT_TAIL] = 1'b0;
      tick();
      check("oob_err_pulse", int'(err), 0);
    end

    // reset 100 cycles into a sweep
    clr_color = 4'd2; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (99) tick();
    check("pre_rst_busy", int'(clr_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_addr", int'(vram_addr), 0);
    check("rst_din", int'(vram_din), 0);
    check("rst_busy", int'(clr_busy), 0);
    check("rst_mem200_kept", mem[200], 7);
    dn = 0;
    repeat (400) begin tick(); if (clr_done) dn++; end
    check("rst_no_done", dn, 0);
    run_sweep(5, 1'b0, bc, ds);
    check("resweep_busy_cycles", bc, CELLS);
    check("resweep_done", int'(ds), 1);
    check("resweep_cells_not5", count_not(5), 0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
